// File: rtl/hid_report_arbiter.sv
// Round-robin arbiter sharing one HID report consumer between two usb_hid_host ports.
// Optional per-port drop counters are built when HID_ARB_DROPCNT_EN is defined.
module hid_report_arbiter #(
    parameter int PAYLOAD_W  = 64,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 usbclk,
    input  logic                 usbrst_n,
    input  logic [1:0]           in_typ0,
    input  logic                 in_valid0,
    input  logic [PAYLOAD_W-1:0] in_data0,
    input  logic [1:0]           in_typ1,
    input  logic                 in_valid1,
    input  logic [PAYLOAD_W-1:0] in_data1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           out_typ,
    output logic                 out_port,
    output logic [1:0]           pending
`ifdef HID_ARB_DROPCNT_EN
    ,
    output logic [CNT_W-1:0]     drop_cnt0,
    output logic [CNT_W-1:0]     drop_cnt1
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    if (CNT_W < 1 || PAYLOAD_W < 1) begin : g_bad_param
        $error("hid_report_arbiter: CNT_W and PAYLOAD_W must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t               state_r;
    logic                 rr_r;
    logic [GAP_W-1:0]     gap_r;
    logic                 out_valid_r;
    logic [PAYLOAD_W-1:0] out_data_r;
    logic [1:0]           out_typ_r;
    logic                 out_port_r;
    logic [1:0]           pending_r;
    logic [PAYLOAD_W-1:0] buf_data_r [2];

    logic [1:0]           in_typ_s   [2];
    logic [PAYLOAD_W-1:0] in_data_s  [2];
    logic [1:0]           in_valid_s;
    logic [1:0]           eligible_s;
    logic                 grant_s;
    logic                 grant_port_s;
    logic [1:0]           grant_vec_s;

    assign in_typ_s[0]  = in_typ0;
    assign in_typ_s[1]  = in_typ1;
    assign in_data_s[0] = in_data0;
    assign in_data_s[1] = in_data1;
    assign in_valid_s   = {in_valid1, in_valid0};

    // A disconnecting port is never granted, even on the edge its flag is being flushed.
    assign eligible_s[0] = pending_r[0] & (in_typ0 != 2'd0);
    assign eligible_s[1] = pending_r[1] & (in_typ1 != 2'd0);

    // Round-robin grant decision, only taken while idle.
    always_comb begin
        grant_s      = 1'b0;
        grant_port_s = 1'b0;
        if (state_r == ST_IDLE && eligible_s != 2'b00) begin
            grant_s = 1'b1;
            if (eligible_s == 2'b11) begin
                grant_port_s = rr_r;
            end else begin
                grant_port_s = eligible_s[1];
            end
        end else begin
            grant_s      = 1'b0;
            grant_port_s = 1'b0;
        end
    end

    assign grant_vec_s = grant_s ? (grant_port_s ? 2'b10 : 2'b01) : 2'b00;

`ifdef HID_ARB_DROPCNT_EN
    logic [CNT_W-1:0] drop_cnt_r [2];
    assign drop_cnt0 = drop_cnt_r[0];
    assign drop_cnt1 = drop_cnt_r[1];
`endif

    // Per-port one-deep report buffers; latest report wins, disconnect flushes.
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            pending_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                buf_data_r[i] <= '0;
`ifdef HID_ARB_DROPCNT_EN
                drop_cnt_r[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (in_typ_s[i] == 2'd0) begin
                    pending_r[i] <= 1'b0;
                end else if (in_valid_s[i]) begin
                    buf_data_r[i] <= in_data_s[i];
                    pending_r[i]  <= 1'b1;
`ifdef HID_ARB_DROPCNT_EN
                    // A buffered report granted on this very edge is not lost.
                    if (pending_r[i] && !grant_vec_s[i] && drop_cnt_r[i] != {CNT_W{1'b1}}) begin
                        drop_cnt_r[i] <= drop_cnt_r[i] + CNT_W'(1);
                    end
`endif
                end else if (grant_vec_s[i]) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Grant / present / holdoff sequencing with registered consumer-side outputs.
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            state_r     <= ST_IDLE;
            rr_r        <= 1'b0;
            gap_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_typ_r   <= 2'd0;
            out_port_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        out_data_r  <= buf_data_r[grant_port_s];
                        out_typ_r   <= in_typ_s[grant_port_s];
                        out_port_r  <= grant_port_s;
                        out_valid_r <= 1'b1;
                        rr_r        <= ~grant_port_s;
                        state_r     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_r <= ST_IDLE;
                        end else begin
                            gap_r   <= GAP_W'(GAP_CYCLES);
                            state_r <= ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (gap_r <= GAP_W'(1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_r <= gap_r - GAP_W'(1);
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_typ   = out_typ_r;
    assign out_port  = out_port_r;
    assign pending   = pending_r;

endmodule

// File: tb/tb_hid_report_arbiter.sv
// Self-checking bench for hid_report_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (one instance with no holdoff, one with a 5-cycle gap).
module tb_hid_report_arbiter;

    localparam int PW  = 64;
    localparam int CW  = 8;

    logic          usbclk;
    logic          usbrst_n;
    logic [1:0]    in_typ0, in_typ1;
    logic          in_valid0, in_valid1;
    logic [PW-1:0] in_data0, in_data1;
    logic          out_ready;

    logic          o0_valid, o0_port;
    logic [PW-1:0] o0_data;
    logic [1:0]    o0_typ, o0_pending;
    logic          o5_valid, o5_port;
    logic [PW-1:0] o5_data;
    logic [1:0]    o5_typ, o5_pending;
`ifdef HID_ARB_DROPCNT_EN
    logic [CW-1:0] o0_drop0, o0_drop1, o5_drop0, o5_drop1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    hid_report_arbiter #(.PAYLOAD_W(PW), .GAP_CYCLES(0), .CNT_W(CW)) dut0 (
        .usbclk(usbclk), .usbrst_n(usbrst_n),
        .in_typ0(in_typ0), .in_valid0(in_valid0), .in_data0(in_data0),
        .in_typ1(in_typ1), .in_valid1(in_valid1), .in_data1(in_data1),
        .out_valid(o0_valid), .out_ready(out_ready), .out_data(o0_data),
        .out_typ(o0_typ), .out_port(o0_port), .pending(o0_pending)
`ifdef HID_ARB_DROPCNT_EN
        , .drop_cnt0(o0_drop0), .drop_cnt1(o0_drop1)
`endif
    );

    hid_report_arbiter #(.PAYLOAD_W(PW), .GAP_CYCLES(5), .CNT_W(CW)) dut5 (
        .usbclk(usbclk), .usbrst_n(usbrst_n),
        .in_typ0(in_typ0), .in_valid0(in_valid0), .in_data0(in_data0),
        .in_typ1(in_typ1), .in_valid1(in_valid1), .in_data1(in_data1),
        .out_valid(o5_valid), .out_ready(out_ready), .out_data(o5_data),
        .out_typ(o5_typ), .out_port(o5_port), .pending(o5_pending)
`ifdef HID_ARB_DROPCNT_EN
        , .drop_cnt0(o5_drop0), .drop_cnt1(o5_drop1)
`endif
    );

    initial usbclk = 1'b0;
    always #5 usbclk = ~usbclk;

    // Reference model of dut0: slots per port, an output register, and an
    // earliest-grant time that encodes the post-handshake holdoff.
    localparam int M_GAP = 0;
    logic          m_pend [2];
    logic [PW-1:0] m_buf  [2];
    int            m_drop [2];
    logic          m_present, m_rr, m_port;
    logic [PW-1:0] m_data;
    logic [1:0]    m_typ;
    longint        m_cyc, m_next_ok;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0; m_buf[i] = '0; m_drop[i] = 0;
        end
        m_present = 1'b0; m_rr = 1'b0; m_port = 1'b0; m_data = '0; m_typ = 2'd0;
        m_cyc = 0; m_next_ok = 0;
    endtask

    task automatic model_step();
        logic [1:0]    typ [2];
        logic          vld [2];
        logic [PW-1:0] dat [2];
        logic          elig [2];
        logic          gnt [2];
        logic          gp;
        typ[0] = in_typ0;   typ[1] = in_typ1;
        vld[0] = in_valid0; vld[1] = in_valid1;
        dat[0] = in_data0;  dat[1] = in_data1;
        for (int i = 0; i < 2; i++) begin
            elig[i] = m_pend[i] && (typ[i] != 2'd0);
            gnt[i]  = 1'b0;
        end
        if (!m_present && m_cyc >= m_next_ok && (elig[0] || elig[1])) begin
            gp = (elig[0] && elig[1]) ? m_rr : elig[1];
            gnt[gp]   = 1'b1;
            m_rr      = !gp;
            m_present = 1'b1;
            m_data    = m_buf[gp];
            m_typ     = typ[gp];
            m_port    = gp;
        end else if (m_present && out_ready) begin
            m_present = 1'b0;
            m_next_ok = m_cyc + M_GAP + 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (typ[i] == 2'd0) begin
                m_pend[i] = 1'b0;
            end else if (vld[i]) begin
                if (m_pend[i] && !gnt[i] && m_drop[i] < (1 << CW) - 1) m_drop[i]++;
                m_buf[i]  = dat[i];
                m_pend[i] = 1'b1;
            end else if (gnt[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        m_cyc++;
    endtask

    task automatic tick();
        model_step();
        @(posedge usbclk);
        #1;
    endtask

    task automatic do_reset();
        usbrst_n = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_data0 = '0; in_data1 = '0;
        in_typ0 = 2'd2; in_typ1 = 2'd1;
        out_ready = 1'b0;
        repeat (2) @(posedge usbclk);
        #1;
        model_reset();
        usbrst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({o0_valid, o0_data, o0_typ, o0_port, o0_pending} !== '0)
            $display("FAIL reset_dut0: got v=%b d=%h t=%0d p=%b pend=%b want all zero", o0_valid, o0_data, o0_typ, o0_port, o0_pending);
        else n_pass++;
        n_checks++;
        if ({o5_valid, o5_data, o5_typ, o5_port, o5_pending} !== '0)
            $display("FAIL reset_dut5: got v=%b d=%h pend=%b want all zero", o5_valid, o5_data, o5_pending);
        else n_pass++;
`ifdef HID_ARB_DROPCNT_EN
        n_checks++;
        if ({o0_drop0, o0_drop1} !== '0) $display("FAIL reset_drop: got %0d/%0d want 0/0", o0_drop0, o0_drop1);
        else n_pass++;
`endif
    endtask

    // in_valid0 raised just after edge N: captured at N+1, presented after N+2.
    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        in_valid0 = 1'b1; in_data0 = 64'h0000_0000_0004_0000;
        tick();
        in_valid0 = 1'b0;
        n_checks++;
        if (o0_valid !== 1'b0 || o0_pending !== 2'b01)
            $display("FAIL single_capture: got v=%b pend=%b want v=0 pend=01", o0_valid, o0_pending);
        else n_pass++;
        tick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_data !== 64'h0000_0000_0004_0000 || o0_port !== 1'b0 || o0_typ !== 2'd2 || o0_pending !== 2'b00)
            $display("FAIL single_present: got v=%b d=%h p=%b t=%0d pend=%b want v=1 d=40000 p=0 t=2 pend=00", o0_valid, o0_data, o0_port, o0_typ, o0_pending);
        else n_pass++;
        tick();
        n_checks++;
        if (o0_valid !== 1'b0) $display("FAIL single_handshake: got v=%b want 0", o0_valid);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [PW-1:0] a, b, c, d, e;
        a = 64'hAAAA_0000_0000_0001; b = 64'hBBBB_0000_0000_0002; c = 64'hCCCC_0000_0000_0003;
        d = 64'hDDDD_0000_0000_0004; e = 64'hEEEE_0000_0000_0005;
        do_reset();
        out_ready = 1'b1;
        in_valid0 = 1'b1; in_data0 = a; in_valid1 = 1'b1; in_data1 = b;
        tick();
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        tick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_port !== 1'b0 || o0_data !== a || o0_pending !== 2'b10)
            $display("FAIL contend_first: got v=%b p=%b d=%h pend=%b want v=1 p=0 d=%h pend=10", o0_valid, o0_port, o0_data, o0_pending, a);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_port !== 1'b1 || o0_data !== b || o0_typ !== 2'd1)
            $display("FAIL contend_second: got v=%b p=%b d=%h t=%0d want v=1 p=1 d=%h t=1", o0_valid, o0_port, o0_data, o0_typ, b);
        else n_pass++;
        tick();
        // a lone port-0 grant points the round-robin at port 1 for the next tie
        in_valid0 = 1'b1; in_data0 = c;
        tick();
        in_valid0 = 1'b0;
        tick();
        tick();
        in_valid0 = 1'b1; in_data0 = d; in_valid1 = 1'b1; in_data1 = e;
        tick();
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        tick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_port !== 1'b1 || o0_data !== e)
            $display("FAIL contend_rr_first: got v=%b p=%b d=%h want v=1 p=1 d=%h", o0_valid, o0_port, o0_data, e);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_port !== 1'b0 || o0_data !== d)
            $display("FAIL contend_rr_second: got v=%b p=%b d=%h want v=1 p=0 d=%h", o0_valid, o0_port, o0_data, d);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] a, b;
        int bad;
        a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210;
        do_reset();
        in_valid0 = 1'b1; in_data0 = a;
        tick();
        in_valid0 = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid0 = (i == 5); in_data0 = (i == 5) ? b : '0;
            tick();
            if (o0_valid !== 1'b1 || o0_data !== a || o0_port !== 1'b0 || o0_typ !== 2'd2) bad++;
        end
        in_valid0 = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (o0_pending !== 2'b01) $display("FAIL bp_pending: got %b want 01", o0_pending);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (o0_valid !== 1'b0) $display("FAIL bp_handshake: got v=%b want 0", o0_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_data !== b || o0_port !== 1'b0)
            $display("FAIL bp_second: got v=%b d=%h p=%b want v=1 d=%h p=0", o0_valid, o0_data, o0_port, b);
        else n_pass++;
        tick();
    endtask

    task automatic test_overwrite();
        logic [PW-1:0] p [3];
        p[0] = 64'h1111; p[1] = 64'h2222; p[2] = 64'h3333;
        do_reset();
        in_valid0 = 1'b1; in_data0 = 64'h9999;
        tick();
        in_valid0 = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            in_valid1 = 1'b1; in_data1 = p[k];
            tick();
            in_valid1 = 1'b0;
            tick();
        end
        n_checks++;
        if (o0_pending !== 2'b10 || o0_valid !== 1'b1 || o0_port !== 1'b0)
            $display("FAIL ovw_state: got pend=%b v=%b p=%b want pend=10 v=1 p=0", o0_pending, o0_valid, o0_port);
        else n_pass++;
`ifdef HID_ARB_DROPCNT_EN
        n_checks++;
        if (o0_drop1 !== 8'd2 || o0_drop0 !== 8'd0)
            $display("FAIL ovw_dropcnt: got %0d/%0d want 0/2", o0_drop0, o0_drop1);
        else n_pass++;
`endif
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_port !== 1'b1 || o0_data !== p[2])
            $display("FAIL ovw_latest: got v=%b p=%b d=%h want v=1 p=1 d=%h", o0_valid, o0_port, o0_data, p[2]);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (o0_valid !== 1'b0 || o0_pending !== 2'b00)
            $display("FAIL ovw_nomore: got v=%b pend=%b want v=0 pend=00", o0_valid, o0_pending);
        else n_pass++;
    endtask

    task automatic test_disconnect();
        int extra;
        do_reset();
        in_valid0 = 1'b1; in_data0 = 64'hA0A0;
        tick();
        in_valid0 = 1'b0;
        tick();
        in_valid1 = 1'b1; in_data1 = 64'hB1B1;
        tick();
        in_valid1 = 1'b0;
        n_checks++;
        if (o0_pending !== 2'b10) $display("FAIL disc_pending_set: got %b want 10", o0_pending);
        else n_pass++;
        in_typ1 = 2'd0; in_valid1 = 1'b1; in_data1 = 64'hC2C2;
        tick();
        in_valid1 = 1'b0;
        n_checks++;
        if (o0_pending !== 2'b00) $display("FAIL disc_flush: got %b want 00", o0_pending);
        else n_pass++;
        in_typ0 = 2'd0;
        tick();
        n_checks++;
        if (o0_valid !== 1'b1 || o0_typ !== 2'd2 || o0_data !== 64'hA0A0)
            $display("FAIL disc_presented_kept: got v=%b t=%0d d=%h want v=1 t=2 d=a0a0", o0_valid, o0_typ, o0_data);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        in_typ0 = 2'd2; in_typ1 = 2'd1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o0_valid !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL disc_no_port1: got %0d cycles with out_valid want 0", extra);
        else n_pass++;
    endtask

    task automatic test_holdoff();
        int bad;
        do_reset();
        out_ready = 1'b1;
        in_valid0 = 1'b1; in_data0 = 64'h5A5A; in_valid1 = 1'b1; in_data1 = 64'hA5A5;
        tick();
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        tick();
        n_checks++;
        if (o5_valid !== 1'b1 || o5_port !== 1'b0 || o5_data !== 64'h5A5A)
            $display("FAIL hold_first: got v=%b p=%b d=%h want v=1 p=0 d=5a5a", o5_valid, o5_port, o5_data);
        else n_pass++;
        tick();
        bad = 0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (o5_valid !== (j == 6)) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL hold_gap: got %0d wrong cycles want second valid exactly 6 after handshake", bad);
        else n_pass++;
        n_checks++;
        if (o5_port !== 1'b1 || o5_data !== 64'hA5A5)
            $display("FAIL hold_second: got p=%b d=%h want p=1 d=a5a5", o5_port, o5_data);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid0 = 1'b1; in_data0 = 64'h7777;
        tick();
        in_valid0 = 1'b0;
        tick();
        #2;
        usbrst_n = 1'b0;
        #1;
        n_checks++;
        if ({o0_valid, o0_data, o0_typ, o0_port, o0_pending} !== '0 || o5_valid !== 1'b0)
            $display("FAIL async_reset: got v=%b d=%h t=%0d p=%b pend=%b v5=%b want all zero", o0_valid, o0_data, o0_typ, o0_port, o0_pending, o5_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [69:0] got, exp;
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid0 = ($urandom_range(0, 3) == 0);
            in_valid1 = ($urandom_range(0, 3) == 0);
            in_data0  = {$urandom, $urandom};
            in_data1  = {$urandom, $urandom};
            in_typ0   = ($urandom_range(0, 19) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            in_typ1   = ($urandom_range(0, 19) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            got = {o0_valid, o0_port, o0_typ, o0_data, o0_pending};
            exp = {m_present, m_port, m_typ, m_data, m_pend[1], m_pend[0]};
            n_checks++;
            if (got !== exp) begin
                if (bad < 10) $display("FAIL random_cycle%0d: got %h want %h", i, got, exp);
                else $display("FAIL random_cycle%0d", i);
                bad++;
            end else n_pass++;
`ifdef HID_ARB_DROPCNT_EN
            n_checks++;
            if (o0_drop0 !== CW'(m_drop[0]) || o0_drop1 !== CW'(m_drop[1]))
                $display("FAIL random_drop%0d: got %0d/%0d want %0d/%0d", i, o0_drop0, o0_drop1, m_drop[0], m_drop[1]);
            else n_pass++;
`endif
        end
        in_valid0 = 1'b0; in_valid1 = 1'b0;
    endtask

    initial begin
        usbrst_n = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overwrite();
        test_disconnect();
        test_holdoff();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
